// File: rtl/wcu_timer.sv
// -----------------------------------------------------------------------------
// wcu_timer
//
// Cycle timer paired with the wash control unit FSM. The FSM selects one of
// four programmable durations with ts and pulses tr to load and start it; the
// timer counts the duration down in prescaled time units and raises cf when
// it has elapsed.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   ts         in   2      timer select, sampled only on edges with tr=1
//   tr         in   1      timer restart (load-and-start), level-sampled
//   pause      in   1      freezes counting while 1 (RUN only)
//   cf         out  1      count finished, registered level (DONE state)
//   busy       out  1      1 while counting (RUN state)
//   remaining  out  CNT_W  time units left, registered
//
// Request semantics: tr is not a valid/ready handshake. Every rising edge that
// sees tr=1 performs a load, regardless of state or pause, and there is no
// backpressure; holding tr high reloads on every edge.
//
// Build option: define WCU_TIMER_FASTSIM_EN to remove the prescaler so that
// every unpaused RUN cycle consumes one whole time unit (fast simulation).
// -----------------------------------------------------------------------------
module wcu_timer #(
    parameter int CNT_W    = 16,
    parameter int PRESCALE = 100,
    parameter int T_IDLE   = 0,
    parameter int T_FILL   = 30,
    parameter int T_WASH   = 600,
    parameter int T_SPIN   = 120
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       ts,
    input  logic             tr,
    input  logic             pause,
    output logic             cf,
    output logic             busy,
    output logic [CNT_W-1:0] remaining
);

    // Durations are truncated to the counter width.
    localparam logic [CNT_W-1:0] DUR_IDLE = CNT_W'(T_IDLE);
    localparam logic [CNT_W-1:0] DUR_FILL = CNT_W'(T_FILL);
    localparam logic [CNT_W-1:0] DUR_WASH = CNT_W'(T_WASH);
    localparam logic [CNT_W-1:0] DUR_SPIN = CNT_W'(T_SPIN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] dur_sel;
    logic             tick;

`ifndef WCU_TIMER_FASTSIM_EN
    // Prescaler only needs to hold PRESCALE-1; keep at least one bit.
    localparam int              PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q, ps_d;
`endif

    always_comb begin
        dur_sel = DUR_IDLE;
        case (ts)
            2'b00:   dur_sel = DUR_IDLE;
            2'b01:   dur_sel = DUR_FILL;
            2'b10:   dur_sel = DUR_WASH;
            default: dur_sel = DUR_SPIN;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        tick    = 1'b0;
`ifndef WCU_TIMER_FASTSIM_EN
        ps_d    = ps_q;
`endif
        if (tr) begin
            // Load wins over everything, including pause and DONE.
            rem_d   = dur_sel;
`ifndef WCU_TIMER_FASTSIM_EN
            ps_d    = '0;
`endif
            state_d = (dur_sel != '0) ? ST_RUN : ST_DONE;
        end else if (state_q == ST_RUN && !pause) begin
`ifdef WCU_TIMER_FASTSIM_EN
            tick = 1'b1;
`else
            tick = (ps_q == PS_MAX);
            ps_d = tick ? '0 : ps_q + PS_W'(1);
`endif
            // RUN is only entered with a nonzero count, so the guard merely
            // makes the no-wrap property explicit.
            if (tick && rem_q != '0) begin
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
`ifndef WCU_TIMER_FASTSIM_EN
            ps_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
`ifndef WCU_TIMER_FASTSIM_EN
            ps_q    <= ps_d;
`endif
        end
    end

    assign cf        = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN);
    assign remaining = rem_q;

endmodule

// File: tb/tb_wcu_timer.sv
// -----------------------------------------------------------------------------
// tb_wcu_timer
//
// Directed and randomized bench for wcu_timer. The reference model tracks the
// total number of unpaused clock cycles left until cf, and derives the
// remaining time units from it with a ceiling division.
// -----------------------------------------------------------------------------
module tb_wcu_timer;

    localparam int CNT_W    = 8;
    localparam int PRESCALE = 4;
    localparam int T_IDLE   = 0;
    localparam int T_FILL   = 3;
    localparam int T_WASH   = 5;
    localparam int T_SPIN   = 2;
    localparam int W        = CNT_W + 2;

`ifdef WCU_TIMER_FASTSIM_EN
    localparam int PS_EFF = 1;
`else
    localparam int PS_EFF = PRESCALE;
`endif

    // ---------------- clock / reset ----------------
    logic             clk;
    logic             reset;
    logic [1:0]       ts;
    logic             tr;
    logic             pause;
    logic             cf;
    logic             busy;
    logic [CNT_W-1:0] remaining;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wcu_timer #(
        .CNT_W   (CNT_W),
        .PRESCALE(PRESCALE),
        .T_IDLE  (T_IDLE),
        .T_FILL  (T_FILL),
        .T_WASH  (T_WASH),
        .T_SPIN  (T_SPIN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ts       (ts),
        .tr       (tr),
        .pause    (pause),
        .cf       (cf),
        .busy     (busy),
        .remaining(remaining)
    );

    // ---------------- reference model ----------------
    // m_mode: 0 idle, 1 counting, 2 finished. m_cyc: unpaused cycles left.
    int m_mode;
    int m_cyc;

    function automatic int dur_units(input logic [1:0] sel);
        int d;
        case (sel)
            2'b00:   d = T_IDLE;
            2'b01:   d = T_FILL;
            2'b10:   d = T_WASH;
            default: d = T_SPIN;
        endcase
        return d % (1 << CNT_W);
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_cyc  = 0;
    endtask

    task automatic model_edge(input logic tr_v, input logic [1:0] ts_v, input logic p_v);
        int d;
        if (tr_v) begin
            d      = dur_units(ts_v);
            m_cyc  = d * PS_EFF;
            m_mode = (d != 0) ? 1 : 2;
        end else if (m_mode == 1 && !p_v) begin
            m_cyc = m_cyc - 1;
            if (m_cyc == 0) m_mode = 2;
        end
    endtask

    function automatic logic [W-1:0] model_out();
        int units;
        units = (m_mode == 1) ? (m_cyc + PS_EFF - 1) / PS_EFF : 0;
        return {(m_mode == 2), (m_mode == 1), CNT_W'(units)};
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed cf/busy/rem=%b/%b/%0d expected=%b/%b/%0d",
                   tag, obs[W-1], obs[W-2], obs[CNT_W-1:0],
                   expv[W-1], expv[W-2], expv[CNT_W-1:0]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic tr_v, input logic [1:0] ts_v, input logic p_v, input string tag);
        @(negedge clk);
        tr    = tr_v;
        ts    = ts_v;
        pause = p_v;
        model_edge(tr_v, ts_v, p_v);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        check(tag, {cf, busy, remaining}, exp_q.pop_front());
    endtask

    task automatic idle_step(input string tag);
        step(1'b0, 2'($urandom_range(0, 3)), 1'b0, tag);
    endtask

    // Assert reset between edges and check outputs clear before the next edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check(tag, {cf, busy, remaining}, model_out());
        check({tag, "_lit"}, {cf, busy, remaining}, '0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        tr    = 1'b0;
        ts    = 2'b00;
        pause = 1'b0;
        model_reset();
        #1;
        reset = 1'b1;
        #1;
        check("reset_state", {cf, busy, remaining}, '0);
        @(negedge clk);
        reset = 1'b0;

        // 1: fill duration, then long DONE hold
        step(1'b1, 2'b01, 1'b0, "t1_load");
`ifndef WCU_TIMER_FASTSIM_EN
        check("t1_after_load", {cf, busy, remaining}, {1'b0, 1'b1, 8'd3});
        for (int i = 1; i <= 12; i++) begin
            idle_step("t1_run");
            if (i == 4)  check("t1_edge4",  {cf, busy, remaining}, {1'b0, 1'b1, 8'd2});
            if (i == 8)  check("t1_edge8",  {cf, busy, remaining}, {1'b0, 1'b1, 8'd1});
            if (i == 12) check("t1_edge12", {cf, busy, remaining}, {1'b1, 1'b0, 8'd0});
        end
`else
        for (int i = 1; i <= 3; i++) idle_step("t1_run");
`endif
        for (int i = 0; i < 20; i++) step(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "t1_hold");

        // 2: pause for 5 cycles after edge 6
        step(1'b1, 2'b01, 1'b0, "t2_load");
        for (int i = 1; i <= 17; i++) begin
            step(1'b0, 2'b01, (i >= 7 && i <= 11), "t2_run");
`ifndef WCU_TIMER_FASTSIM_EN
            if (i == 9)  check("t2_frozen", {cf, busy, remaining}, {1'b0, 1'b1, 8'd2});
            if (i == 16) check("t2_edge16", {cf, busy, remaining}, {1'b0, 1'b1, 8'd1});
            if (i == 17) check("t2_edge17", {cf, busy, remaining}, {1'b1, 1'b0, 8'd0});
`endif
        end

        // 3: wash load, reload with spin mid-count
        step(1'b1, 2'b10, 1'b0, "t3_load");
        for (int i = 1; i <= 8; i++) idle_step("t3_run_a");
        step(1'b1, 2'b11, 1'b0, "t3_reload");
`ifndef WCU_TIMER_FASTSIM_EN
        check("t3_edge9", {cf, busy, remaining}, {1'b0, 1'b1, 8'd2});
`endif
        for (int i = 10; i <= 17; i++) idle_step("t3_run_b");
`ifndef WCU_TIMER_FASTSIM_EN
        check("t3_edge17", {cf, busy, remaining}, {1'b1, 1'b0, 8'd0});
`endif

        // 4: zero-duration load from DONE, then real load
        step(1'b1, 2'b00, 1'b0, "t4_zero_load");
        check("t4_zero_lit", {cf, busy, remaining}, {1'b1, 1'b0, 8'd0});
        step(1'b1, 2'b01, 1'b0, "t4_fill_load");
        check("t4_fill_lit", {cf, busy}, 2'b01);
        // back-to-back tr reloads keep cf low
        for (int i = 0; i < 4; i++) step(1'b1, 2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), "t4_reload");

        // 5: async reset mid-count
        step(1'b1, 2'b01, 1'b0, "t5_load");
        for (int i = 1; i <= 4; i++) idle_step("t5_run");
        async_reset("t5_reset");
        for (int i = 0; i < 20; i++) step(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "t5_idle");

`ifdef WCU_TIMER_FASTSIM_EN
        // 6: fast build, one unit per edge
        step(1'b1, 2'b10, 1'b0, "t6_load");
        for (int i = 1; i <= 5; i++) idle_step("t6_run");
        check("t6_edge5", {cf, busy, remaining}, {1'b1, 1'b0, 8'd0});
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 11) == 0), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0), "rand");
            if ($urandom_range(0, 199) == 0) async_reset("rand_reset");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wcu_timer.md
Name: wcu_timer

Overview:
- Cycle timer that is the counterpart of the wash control unit (wcu) FSM.
- Consumes the FSM's timer select (ts) and timer restart (tr) outputs and produces the count-finished flag (cf) the FSM waits on.
- Holds one programmable duration per ts code and counts in prescaled time units.
- Exposes busy and remaining-time status for display/debug.

Parameters:
- CNT_W, 16, width of the time-unit down-counter and the remaining output.
- PRESCALE, 100, clock cycles per time unit (>=1); the prescaler is sized to fit PRESCALE-1.
- T_IDLE, 0, duration in units for ts=2'b00.
- T_FILL, 30, duration in units for ts=2'b01.
- T_WASH, 600, duration in units for ts=2'b10.
- T_SPIN, 120, duration in units for ts=2'b11.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ts  input  2  timer select from the FSM; sampled only on cycles with tr=1.
- tr  input  1  timer restart; load-and-start request, level-sampled every edge.
- pause  input  1  freezes counting while 1 (lid/fault hold).
- cf  output  1  count finished; registered level.
- busy  output  1  1 while counting (RUN state).
- remaining  output  CNT_W  time units left; registered.

Behaviour:
- Reset: async. State IDLE; cf=0, busy=0, remaining=0, prescaler=0. Applies immediately, including mid-count.
- States:
  - IDLE: cf=0, busy=0.
  - RUN: cf=0, busy=1.
  - DONE: cf=1, busy=0.
- Load (highest priority, any state, including when pause=1), on an edge with tr=1:
  - remaining <= duration(ts); prescaler <= 0.
  - Next state is RUN if duration(ts)!=0, else DONE.
  - cf therefore drops the cycle after the tr edge. The FSM's one-cycle tr pulse always clears a previous cf before the FSM re-tests cf.
- RUN with tr=0 and pause=0:
  - If prescaler==PRESCALE-1: prescaler wraps to 0 and remaining decrements.
  - Otherwise prescaler increments.
  - The decrement that produces remaining==0 moves the state to DONE on the same edge.
- RUN with pause=1 and tr=0: prescaler, remaining and state hold.
- DONE: holds cf=1 indefinitely until the next tr; pause has no effect.
- IDLE: remains until tr.
- Latency: cf rises exactly duration(ts)*PRESCALE edges after the load edge, plus one edge per paused RUN cycle.
- Durations are truncated to CNT_W bits. There is no counter wrap: remaining never decrements below 0.
- ts changes while tr=0 are ignored; only the value sampled at load matters.
- tr asserted on consecutive edges reloads each time; cf stays 0 throughout.

Optional Feature:
- Macro WCU_TIMER_FASTSIM_EN.
  - Defined: the prescaler is removed and every RUN cycle with pause=0 decrements remaining. Latency becomes duration(ts) edges; used for fast simulation of full wash sequences.
  - Undefined: the PRESCALE behaviour above.
- Ports and parameters are identical in both builds.

Test Plan (PRESCALE=4, T_IDLE=0, T_FILL=3, T_WASH=5, T_SPIN=2, CNT_W=8 unless noted):
1. ts=01, one-cycle tr at edge 0 -> busy=1 and remaining=3 after edge 0; remaining=2 after edge 4 and 1 after edge 8; cf=1, busy=0, remaining=0 after edge 12; cf stays 1 for 20 further cycles.
2. As 1, with pause=1 for 5 cycles starting after edge 6 -> remaining frozen at 2; cf rises after edge 17, not before.
3. ts=10 load, then at edge 9 (remaining=3) tr with ts=11 -> remaining=2 after edge 9; cf=0 throughout; cf=1 after edge 17.
4. cf=1 in DONE, then tr with ts=00 -> cf=1 again after the load edge; busy never 1. Then tr with ts=01 -> cf=0 on the next cycle.
5. Async reset asserted between edges mid-RUN (remaining=2) -> cf=0, busy=0, remaining=0 before the next edge. After release, with no tr, the timer stays idle for 20 cycles.
6. WCU_TIMER_FASTSIM_EN defined, ts=10 tr at edge 0 -> remaining decrements every edge; cf=1 after edge 5.
